// File: rtl/pl_stage_3.sv
// pl_stage_3: computes b_hat[i] = (a_hat[i] * s_hat[i] + e_hat[i]) mod Q.
// Reads s_hat, e_hat and a_hat through three synchronous read ports that share
// one index, and streams results to the next stage's write port.
// Pipeline: address issue -> RAM data -> multiply-add -> Barrett reduce/write.
module pl_stage_3 #(
  parameter int N = 512,
  parameter int Q = 12289
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start_stage,
  output logic        done_stage,
  output logic [8:0]  addr_sp,
  input  logic [15:0] do_sp,
  output logic [8:0]  addr_ep,
  input  logic [15:0] do_ep,
  output logic [8:0]  addr_a,
  input  logic [15:0] do_a,
  output logic        we_b,
  output logic [8:0]  addr_b,
  output logic [15:0] dout_b
);

  localparam logic [8:0]  LAST_IDX  = 9'(N - 1);
  localparam logic [27:0] Q_W       = 28'(Q);
  // Barrett constant: floor(2^42 / Q). For x < 2^28 the quotient estimate is
  // at most one below the true quotient, so one conditional subtract suffices.
  localparam int          BARRETT_K = 42;
  localparam logic [63:0] BARRETT_M = (64'd1 << BARRETT_K) / 64'(Q);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t      state_q;
  logic [8:0]  idx_q;       // read index driven on all three read ports
  logic        rd_v_q;      // RAM data on do_* (or in hold) belongs to an element
  logic [8:0]  rd_idx_q;    // index of that element
  logic        done_q;

  logic        hold_v_q;
  logic [13:0] hold_a_q, hold_s_q, hold_e_q;

  logic        s1_v_q;
  logic [27:0] s1_sum_q;
  logic [8:0]  s1_idx_q;

  logic        we_q;
  logic [8:0]  addr_b_q;
  logic [15:0] dout_q;

  logic [13:0] op_a_d, op_s_d, op_e_d;
  logic [27:0] sum_d;
  logic [63:0] bq_prod_d;
  logic [27:0] q_est_d;
  logic [27:0] r_raw_d;
  logic [13:0] rem_d;

  // Upper two bits of each read word are outside the operand range.
  logic unused_hi;
  assign unused_hi = ^{do_sp[15:14], do_ep[15:14], do_a[15:14]};

  // Control FSM: sequences the read index and raises the one-cycle done pulse.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rd_v_q   <= 1'b0;
      rd_idx_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_stage) begin
            state_q <= RUN;
            idx_q   <= '0;
          end
        end
        RUN: begin
          if (en) begin
            if (idx_q == LAST_IDX) begin
              state_q <= DRAIN;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 9'd1;
            end
          end
        end
        DRAIN: begin
          // Pipeline empty means the last write went out in this cycle.
          if (en && !rd_v_q && !s1_v_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (en) begin
        rd_v_q   <= (state_q == RUN);
        rd_idx_q <= idx_q;
      end
    end
  end

  // Stall capture: the RAMs move on to the next address during a stall, so the
  // word returned in the first stalled cycle is parked until the pipe advances.
  // NOTE: data registers are reset along with their valid flag only so that
  // the block powers up deterministic; correctness relies on the valid flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_v_q <= 1'b0;
      hold_a_q <= '0;
      hold_s_q <= '0;
      hold_e_q <= '0;
    end else if (en) begin
      hold_v_q <= 1'b0;
    end else if (rd_v_q && !hold_v_q) begin
      hold_v_q <= 1'b1;
      hold_a_q <= do_a[13:0];
      hold_s_q <= do_sp[13:0];
      hold_e_q <= do_ep[13:0];
    end
  end

  // Operand select and multiply-add (28 bits cannot overflow).
  // NOTE: every always_comb output is assigned on every path; a missing
  // assignment would infer a latch.
  always_comb begin
    op_a_d = hold_v_q ? hold_a_q : do_a[13:0];
    op_s_d = hold_v_q ? hold_s_q : do_sp[13:0];
    op_e_d = hold_v_q ? hold_e_q : do_ep[13:0];
    sum_d  = 28'(op_a_d) * 28'(op_s_d) + 28'(op_e_d);
  end

  // Stage 1: register the unreduced sum with its index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v_q   <= 1'b0;
      s1_sum_q <= '0;
      s1_idx_q <= '0;
    end else if (en) begin
      s1_v_q   <= rd_v_q;
      s1_sum_q <= sum_d;
      s1_idx_q <= rd_idx_q;
    end
  end

  // Barrett reduction of the stage-1 sum into [0, Q-1].
  always_comb begin
    bq_prod_d = 64'(s1_sum_q) * BARRETT_M;
    q_est_d   = 28'(bq_prod_d >> BARRETT_K);
    r_raw_d   = s1_sum_q - q_est_d * Q_W;
    rem_d     = (r_raw_d >= Q_W) ? 14'(r_raw_d - Q_W) : 14'(r_raw_d);
  end

  // Stage 2: registered write port; a stalled edge never repeats a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q     <= 1'b0;
      addr_b_q <= '0;
      dout_q   <= '0;
    end else if (en) begin
      we_q     <= s1_v_q;
      addr_b_q <= s1_idx_q;
      dout_q   <= {2'b00, rem_d};
    end else begin
      we_q <= 1'b0;
    end
  end

  assign addr_sp    = idx_q;
  assign addr_ep    = idx_q;
  assign addr_a     = idx_q;
  assign we_b       = we_q;
  assign addr_b     = addr_b_q;
  assign dout_b     = dout_q;
  assign done_stage = done_q;

endmodule
